fifo_uart_drain: RTL and testbench

Downstream consumer of the FIFO read port. Whenever enabled and the FIFO is not empty, the block pops one word and serializes it as an 8N1 UART frame on tx_o, LSB first. It then returns to request the next word. It sits between the FIFO and the board TX pin, and drains logged or buffered bytes to a host.

---
 rtl/fifo_uart_drain.sv | 158 +++++++++++++++
 tb/tb_fifo_uart_drain.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_drain.sv
// fifo_uart_drain: pops words from a FIFO read port and sends each one as an
// 8N1 UART frame (start bit, WIDTH data bits LSB first, stop bit) on tx_o.
// A read request that gets no rd_dv_i within DV_TIMEOUT cycles is abandoned
// with an err_o pulse and retried from IDLE.
module fifo_uart_drain #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 217,
    parameter int DV_TIMEOUT   = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             empty_i,
    output logic             rd_en_o,
    input  logic             rd_dv_i,
    input  logic [WIDTH-1:0] rd_data_i,
    output logic             tx_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int TW = (DV_TIMEOUT > 0) ? $clog2(DV_TIMEOUT + 1) : 1;

    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(DV_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DV,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state, state_n;
    logic [CW-1:0]    clk_cnt, clk_cnt_n;
    logic [BW-1:0]    bit_cnt, bit_cnt_n;
    logic [TW-1:0]    to_cnt, to_cnt_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic             tx_n, rd_en_n, busy_n, done_n, err_n;

    // State, counters, shift register and all outputs are registered here.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            to_cnt  <= '0;
            shreg   <= '0;
            tx_o    <= 1'b1;
            rd_en_o <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            state   <= state_n;
            clk_cnt <= clk_cnt_n;
            bit_cnt <= bit_cnt_n;
            to_cnt  <= to_cnt_n;
            shreg   <= shreg_n;
            tx_o    <= tx_n;
            rd_en_o <= rd_en_n;
            busy_o  <= busy_n;
            done_o  <= done_n;
            err_o   <= err_n;
        end
    end

    // Next-state logic; output values are computed one cycle ahead so the
    // pins come straight from flops. tx_n is the level for the next cycle,
    // and the shift register is pre-shifted as each data bit is launched.
    always_comb begin
        state_n   = state;
        clk_cnt_n = clk_cnt;
        bit_cnt_n = bit_cnt;
        to_cnt_n  = to_cnt;
        shreg_n   = shreg;
        tx_n      = tx_o;
        rd_en_n   = 1'b0;
        done_n    = 1'b0;
        err_n     = 1'b0;

        case (state)
            IDLE: begin
                tx_n      = 1'b1;
                clk_cnt_n = '0;
                bit_cnt_n = '0;
                to_cnt_n  = '0;
                if (enable_i && !empty_i) begin
                    rd_en_n = 1'b1;
                    state_n = WAIT_DV;
                end
            end
            WAIT_DV: begin
                if (rd_dv_i) begin
                    shreg_n   = rd_data_i;
                    to_cnt_n  = '0;
                    clk_cnt_n = '0;
                    tx_n      = 1'b0;
                    state_n   = START;
                end else if (to_cnt == TO_LAST) begin
                    to_cnt_n = '0;
                    err_n    = 1'b1;
                    state_n  = IDLE;
                end else begin
                    to_cnt_n = to_cnt + 1'b1;
                end
            end
            START: begin
                if (clk_cnt == CLK_LAST) begin
                    clk_cnt_n = '0;
                    bit_cnt_n = '0;
                    tx_n      = shreg[0];
                    shreg_n   = shreg >> 1;
                    state_n   = DATA;
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
            DATA: begin
                if (clk_cnt == CLK_LAST) begin
                    clk_cnt_n = '0;
                    if (bit_cnt == BIT_LAST) begin
                        tx_n    = 1'b1;
                        state_n = STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                        tx_n      = shreg[0];
                        shreg_n   = shreg >> 1;
                    end
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
            STOP: begin
                tx_n = 1'b1;
                if (clk_cnt == CLK_LAST) begin
                    clk_cnt_n = '0;
                    done_n    = 1'b1;
                    state_n   = IDLE;
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
            default: begin
                tx_n    = 1'b1;
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Bench for fifo_uart_drain: an input-driven frame-level model is compared
// against every output on every falling edge, and directed scenarios check
// captured frames, latencies and pulse counts against literal values.
module tb_fifo_uart_drain;

    localparam int W     = 8;
    localparam int C     = 4;
    localparam int TO    = 4;
    localparam int FRAME = (W + 2) * C;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic         empty;
    logic         rd_en;
    logic         rd_dv;
    logic [W-1:0] rd_data;
    logic         tx;
    logic         busy;
    logic         done;
    logic         err;

    int vectors = 0;
    int fails   = 0;

    fifo_uart_drain #(
        .WIDTH(W),
        .CLKS_PER_BIT(C),
        .DV_TIMEOUT(TO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .enable_i(enable),
        .empty_i(empty),
        .rd_en_o(rd_en),
        .rd_dv_i(rd_dv),
        .rd_data_i(rd_data),
        .tx_o(tx),
        .busy_o(busy),
        .done_o(done),
        .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- FIFO responder (1-cycle read latency) ----------------
    logic [W-1:0] q[$];
    logic         force_empty = 1'b1;
    logic         mute = 1'b0;
    logic         pend = 1'b0;
    logic [W-1:0] pend_data = '0;

    initial begin
        rd_dv   = 1'b0;
        rd_data = '0;
        empty   = 1'b1;
    end

    always @(negedge clk) begin
        rd_dv = 1'b0;
        if (pend) begin
            rd_dv   = 1'b1;
            rd_data = pend_data;
            pend    = 1'b0;
        end
        if (rd_en === 1'b1 && !mute && q.size() > 0) begin
            pend      = 1'b1;
            pend_data = q.pop_front();
        end
        empty = force_empty || (q.size() == 0);
    end

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 waiting for data, 2 sending frame; m_t is the cycle
    // index inside the frame, from which the line level follows directly.
    int           m_mode = 0;
    int           m_wait = 0;
    int           m_t    = 0;
    logic [W-1:0] m_byte = '0;
    logic e_tx = 1'b1, e_rd = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0;

    function automatic logic frame_bit(input logic [W-1:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= W) return b[k-1];
        return 1'b1;
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            #1;
            if (rst) begin
                m_mode = 0;
                e_tx = 1'b1; e_rd = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
            end else begin
                e_rd = 1'b0; e_done = 1'b0; e_err = 1'b0;
                case (m_mode)
                    0: if (enable && !empty) begin
                        m_mode = 1; m_wait = 0; e_rd = 1'b1;
                    end
                    1: if (rd_dv) begin
                        m_byte = rd_data; m_mode = 2; m_t = 0;
                    end else begin
                        m_wait++;
                        if (m_wait == TO) begin
                            e_err = 1'b1; m_mode = 0;
                        end
                    end
                    default: begin
                        m_t++;
                        if (m_t == FRAME) begin
                            e_done = 1'b1; m_mode = 0;
                        end
                    end
                endcase
                e_busy = (m_mode != 0);
                e_tx   = (m_mode == 2) ? frame_bit(m_byte, m_t / C) : 1'b1;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        check("tx",    {31'd0, tx},    {31'd0, e_tx});
        check("rd_en", {31'd0, rd_en}, {31'd0, e_rd});
        check("busy",  {31'd0, busy},  {31'd0, e_busy});
        check("done",  {31'd0, done},  {31'd0, e_done});
        check("err",   {31'd0, err},   {31'd0, e_err});
    end

    // Pulse counters on the DUT outputs.
    int n_rd = 0, n_done = 0, n_err = 0;
    always @(negedge clk) begin
        if (rd_en === 1'b1) n_rd++;
        if (done === 1'b1) n_done++;
        if (err === 1'b1) n_err++;
    end

    // ---------------- directed helpers ----------------
    task automatic wait_rd();
        int k = 0;
        while (rd_en !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("rd_en_seen", {31'd0, rd_en}, 32'd1);
    endtask

    // Samples one frame half a cycle into each bit; may drop enable at a
    // given cycle offset from the start bit.
    task automatic capture(output logic [9:0] bits, input int drop_at);
        int k = 0;
        int cyc = 0;
        while (tx !== 1'b0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("frame_start_seen", {31'd0, tx}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            bits[i] = tx;
            for (int c = 0; c < C; c++) begin
                if (cyc == drop_at) enable = 1'b0;
                @(negedge clk);
                cyc++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, fails=%0d", fails);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [9:0] f1, f2;
        int r0, d0, e0, lat;

        rst = 1'b1;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset and quiet idle with an empty FIFO.
        enable = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_tx", {31'd0, tx}, 32'd1);
        check("idle_rd_cnt", n_rd, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Single byte 0xAB.
        r0 = n_rd; d0 = n_done;
        q.push_back(8'hAB);
        force_empty = 1'b0;
        wait_rd();
        lat = 0;
        while (tx !== 1'b0 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("latency_rd_to_start", lat, 32'd2);
        capture(f1, -1);
        check("frame_AB", {22'd0, f1}, {22'd0, 10'b1101010110});
        repeat (5) @(negedge clk);
        check("AB_rd_pulses", n_rd - r0, 32'd1);
        check("AB_done_pulses", n_done - d0, 32'd1);
        check("AB_busy_after", {31'd0, busy}, 32'd0);

        // Back-to-back 0x55 then 0x0F.
        r0 = n_rd; d0 = n_done;
        q.push_back(8'h55);
        q.push_back(8'h0F);
        capture(f1, -1);
        capture(f2, -1);
        check("frame_55", {22'd0, f1}, {22'd0, 10'b1010101010});
        check("frame_0F", {22'd0, f2}, {22'd0, 10'b1000011110});
        repeat (20) @(negedge clk);
        check("b2b_rd_pulses", n_rd - r0, 32'd2);
        check("b2b_done_pulses", n_done - d0, 32'd2);

        // enable dropped 10 cycles into a frame, FIFO still non-empty.
        r0 = n_rd; d0 = n_done;
        q.push_back(8'hAB);
        q.push_back(8'h11);
        capture(f1, 10);
        check("frame_AB_drop", {22'd0, f1}, {22'd0, 10'b1101010110});
        repeat (100) @(negedge clk);
        check("drop_rd_pulses", n_rd - r0, 32'd1);
        check("drop_done_pulses", n_done - d0, 32'd1);
        q.delete();

        // Read-valid timeout and retry.
        e0 = n_err;
        mute = 1'b1;
        q.push_back(8'h77);
        enable = 1'b1;
        wait_rd();
        lat = 0;
        while (err !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("timeout_cycles", lat, TO);
        lat = 0;
        while (rd_en !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("retry_after_err", lat, 32'd1);
        enable = 1'b0;
        repeat (10) @(negedge clk);
        check("err_pulses", n_err - e0, 32'd2);
        mute = 1'b0;
        q.delete();

        // Reset during data bit 3 of 0xA3 (bit 3 is low), then a full 0x0F frame.
        q.push_back(8'hA3);
        q.push_back(8'h0F);
        enable = 1'b1;
        lat = 0;
        while (tx !== 1'b0 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        repeat (4 * C + 1) @(negedge clk);
        check("pre_reset_tx_bit3", {31'd0, tx}, 32'd0);
        rst = 1'b1;
        #1;
        check("reset_tx_immediate", {31'd0, tx}, 32'd1);
        check("reset_busy_immediate", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        r0 = n_rd; d0 = n_done;
        rst = 1'b0;
        capture(f1, -1);
        check("frame_after_reset", {22'd0, f1}, {22'd0, 10'b1000011110});
        enable = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_rd_pulses", n_rd - r0, 32'd1);
        check("reset_done_pulses", n_done - d0, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
